sobel_out_formatter: RTL and testbench

Back end of the edge-detection pixel stream. Consumes the 12-bit gradient magnitude stream produced by the Sobel convolution stage, together with its data-valid strobe, and tracks raster position. Zeroes the border pixels whose 3x3 window is not yet fully populated, and optionally binarizes against a runtime threshold. Delivers pixels with start-of-frame/end-of-line tags through a small FIFO to a valid/ready consumer (frame-buffer writer or display path).

---
 rtl/sobel_out_formatter.sv | 150 +++++++++++++++
 tb/tb_sobel_out_formatter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_out_formatter.sv
// Output formatter for the Sobel gradient stream: raster tracking, border zeroing,
// optional binarization, SOF/EOL tagging and a show-ahead FIFO toward a valid/ready sink.
module sobel_out_formatter #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] pixel_in,
  input  logic        binarize,
  input  logic [11:0] thresh,
  input  logic        iREADY,
  output logic        oVALID,
  output logic [11:0] oDATA,
  output logic        oSOF,
  output logic        oEOL,
  output logic        oOVF
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic          fval_d_reg;
  logic          accept;
  logic          border;
  logic [11:0]   value_next;

  logic          s1_valid_reg;
  logic [13:0]   s1_entry_reg;

  logic [13:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [OW-1:0] mem_cnt_reg;
  logic [OW-1:0] occ;
  logic          out_valid_reg;
  logic [13:0]   out_entry_reg;
  logic          ovf_reg;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic          load;

  assign accept = iFVAL & iDVAL;
  assign border = (32'(x_reg) < 32'd2) || (32'(y_reg) < 32'd2);

  always_comb begin
    value_next = 12'h000;
    if (!border) begin
      if (binarize) begin
        value_next = (pixel_in >= thresh) ? 12'hFFF : 12'h000;
      end else begin
        value_next = pixel_in;
      end
    end
  end

  // Raster position of the pixel currently presented; frame gaps restart at the origin.
  always_ff @(posedge iCLK) begin
    if (!iRST || !iFVAL) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (iDVAL) begin
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      s1_valid_reg <= 1'b0;
      s1_entry_reg <= '0;
      fval_d_reg   <= 1'b0;
    end else begin
      fval_d_reg   <= iFVAL;
      s1_valid_reg <= accept;
      if (accept) begin
        s1_entry_reg <= {(x_reg == '0) && (y_reg == '0), x_reg == X_LAST, value_next};
      end
    end
  end

  // Occupancy counts the RAM entries plus the show-ahead output register.
  assign occ  = mem_cnt_reg + OW'(out_valid_reg);
  assign pop  = out_valid_reg & iREADY;
  assign full = (occ == OCC_FULL);
  assign push = s1_valid_reg & (~full | pop);
  assign drop = s1_valid_reg & full & ~pop;
  assign load = (mem_cnt_reg != '0) & (~out_valid_reg | pop);

  always_ff @(posedge iCLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= s1_entry_reg;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_entry_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        out_entry_reg <= mem[rd_ptr_reg];
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
      mem_cnt_reg <= mem_cnt_reg + OW'(push) - OW'(load);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      ovf_reg <= 1'b0;
    end else if (iFVAL && !fval_d_reg) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end
  end

  assign oVALID = out_valid_reg;
  assign oSOF   = out_entry_reg[13];
  assign oEOL   = out_entry_reg[12];
  assign oDATA  = out_entry_reg[11:0];
  assign oOVF   = ovf_reg;

endmodule

// File: tb/tb_sobel_out_formatter.sv
// Directed bench for sobel_out_formatter on a 4x3 raster with an 8-entry FIFO.
module tb_sobel_out_formatter;

  logic        clk = 1'b0;
  logic        iRST;
  logic        iFVAL;
  logic        iDVAL;
  logic [11:0] pixel_in;
  logic        binarize;
  logic [11:0] thresh;
  logic        iREADY;
  logic        oVALID;
  logic [11:0] oDATA;
  logic        oSOF;
  logic        oEOL;
  logic        oOVF;

  int n_checks = 0;
  int n_err = 0;
  logic [13:0] got_q[$];

  sobel_out_formatter #(.WIDTH(4), .HEIGHT(3), .FIFO_DEPTH(8)) dut (
    .iCLK(clk), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .pixel_in(pixel_in),
    .binarize(binarize), .thresh(thresh), .iREADY(iREADY), .oVALID(oVALID),
    .oDATA(oDATA), .oSOF(oSOF), .oEOL(oEOL), .oOVF(oOVF)
  );

  always #5 clk = ~clk;

  // Record every handshake as {sof, eol, data}.
  always @(negedge clk) begin
    if (iRST && oVALID && iREADY) got_q.push_back({oSOF, oEOL, oDATA});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [11:0] v);
    iDVAL = 1'b1;
    pixel_in = v;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int idx);
    if (idx < got_q.size()) return 32'(got_q[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [13:0] exp_e;
    logic [11:0] v;
    int i;
    iRST = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; pixel_in = '0;
    binarize = 1'b0; thresh = '0; iREADY = 1'b1;
    ticks(2);
    chk("rst_valid", 32'(oVALID), 0);
    chk("rst_data", 32'(oDATA), 0);
    chk("rst_sof", 32'(oSOF), 0);
    chk("rst_eol", 32'(oEOL), 0);
    chk("rst_ovf", 32'(oOVF), 0);
    iRST = 1'b1;

    // Three back-to-back frames: pass-through, binarize, large unsigned values.
    iFVAL = 1'b1;
    tick();
    got_q.delete();
    for (int k = 0; k < 36; k++) begin
      i = k % 12;
      if (k < 12) begin
        binarize = 1'b0; v = 12'h100;
      end else if (k < 24) begin
        binarize = 1'b1; thresh = 12'h080;
        v = (i == 10) ? 12'h07F : (i == 11) ? 12'h080 : 12'hFFF;
      end else begin
        binarize = 1'b0; v = 12'h800;
      end
      send(v);
      if (k == 1) chk("lat_n1_valid", 32'(oVALID), 0);
      if (k == 2) chk("lat_n2_valid", 32'(oVALID), 1);
    end
    iDVAL = 1'b0;
    binarize = 1'b0;
    ticks(6);
    chk("frames_count", got_q.size(), 36);
    for (int k = 0; k < 36; k++) begin
      i = k % 12;
      exp_e = 14'h0000;
      if (i == 0) exp_e[13] = 1'b1;
      if (i % 4 == 3) exp_e[12] = 1'b1;
      if (i >= 10) begin
        if (k < 12) exp_e[11:0] = 12'h100;
        else if (k < 24) exp_e[11:0] = (i == 10) ? 12'h000 : 12'hFFF;
        else exp_e[11:0] = 12'h800;
      end
      chk($sformatf("frame_out_%0d", k), qget(k), 32'(exp_e));
    end
    chk("frames_ovf", 32'(oOVF), 0);

    // Strobes without frame valid are ignored.
    iFVAL = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) send(12'h555);
    iDVAL = 1'b0;
    ticks(4);
    chk("nofval_count", got_q.size(), 36);
    chk("nofval_valid", 32'(oVALID), 0);

    // Overflow: skip to position 8, then 10 pixels with the sink stalled.
    iFVAL = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) send(12'h0AA);
    iDVAL = 1'b0;
    ticks(5);
    got_q.delete();
    iREADY = 1'b0;
    for (int j = 0; j < 10; j++) begin
      send(12'h100 + 12'(j));
      if (j == 8) chk("ovf_before_drop", 32'(oOVF), 0);
      if (j == 9) chk("ovf_after_drop", 32'(oOVF), 1);
    end
    iDVAL = 1'b0;
    ticks(3);
    chk("ovf_sticky", 32'(oOVF), 1);
    chk("ovf_stall_valid", 32'(oVALID), 1);
    chk("ovf_stall_data_stable", 32'(oDATA), 0);
    chk("ovf_no_pops", got_q.size(), 0);
    iREADY = 1'b1;
    ticks(12);
    chk("ovf_pop_count", got_q.size(), 8);
    chk("ovf_e0", qget(0), 32'h0000);
    chk("ovf_e1", qget(1), 32'h0000);
    chk("ovf_e2", qget(2), 32'h0102);
    chk("ovf_e3", qget(3), 32'h1103);
    chk("ovf_e4", qget(4), 32'h2000);
    chk("ovf_e5", qget(5), 32'h0000);
    chk("ovf_e6", qget(6), 32'h0000);
    chk("ovf_e7", qget(7), 32'h1000);
    chk("ovf_hold_after_drain", 32'(oOVF), 1);

    // New frame clears the flag; a push onto a full FIFO with a pop is kept.
    iFVAL = 1'b0;
    tick();
    iFVAL = 1'b1;
    tick();
    chk("ovf_clear_on_fval_rise", 32'(oOVF), 0);
    got_q.delete();
    iREADY = 1'b0;
    for (int j = 0; j < 9; j++) send(12'h0AA);
    iDVAL = 1'b0;
    iREADY = 1'b1;
    tick();
    iREADY = 1'b0;
    ticks(2);
    chk("fullpop_ovf", 32'(oOVF), 0);
    chk("fullpop_one_pop", got_q.size(), 1);
    chk("fullpop_first", qget(0), 32'h2000);
    send(12'h0AA);
    iDVAL = 1'b0;
    tick();
    chk("fullpop_still_full", 32'(oOVF), 1);
    iREADY = 1'b1;
    ticks(12);
    chk("fullpop_total", got_q.size(), 9);
    chk("fullpop_e3", qget(3), 32'h1000);
    chk("fullpop_e7", qget(7), 32'h1000);

    // Mid-frame reset with three entries queued (positions 10, 11, 0).
    iREADY = 1'b0;
    for (int j = 0; j < 3; j++) send(12'h0AA);
    iDVAL = 1'b0;
    ticks(3);
    chk("prerst_valid", 32'(oVALID), 1);
    chk("prerst_data", 32'(oDATA), 32'h0AA);
    iRST = 1'b0;
    tick();
    chk("midrst_valid", 32'(oVALID), 0);
    chk("midrst_ovf", 32'(oOVF), 0);
    chk("midrst_data", 32'(oDATA), 0);
    iRST = 1'b1;
    got_q.delete();
    iREADY = 1'b1;
    send(12'h123);
    iDVAL = 1'b0;
    ticks(5);
    chk("postrst_count", got_q.size(), 1);
    chk("postrst_sof", qget(0), 32'h2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
